// File: rtl/sum_accumulator.sv
// Frame accumulator: sums COUNT unsigned samples (or fewer on flush) from a
// valid/ready stream and holds the total, sample count and overflow flag for a valid/ready consumer.
module sum_accumulator #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int COUNT     = 4,
    localparam int CW       = $clog2(COUNT + 1)
) (
    input  logic                 IN_clk,
    input  logic                 IN_rst_n,
    input  logic                 IN_valid,
    output logic                 OUT_ready,
    input  logic [WIDTH-1:0]     IN_sum,
    input  logic                 IN_flush,
    output logic                 OUT_valid,
    input  logic                 IN_ready,
    output logic [ACC_WIDTH-1:0] OUT_acc,
    output logic [CW-1:0]        OUT_count,
    output logic                 OUT_ovf
);

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high; the producer holds its data stable while valid && !ready.
    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t               r_state, w_state_n;
    logic                 r_ready, w_ready_n;
    logic [ACC_WIDTH-1:0] r_acc, w_acc_n;
    logic [CW-1:0]        r_count, w_count_n;
    logic                 r_ovf, w_ovf_n;

    logic                 w_accept;
    logic                 w_return;
    logic [ACC_WIDTH:0]   w_sum_ext;
    logic [CW-1:0]        w_count_inc;

    assign w_accept    = IN_valid && r_ready;
    assign w_return    = (r_state == HOLD) && IN_ready;
    assign w_sum_ext   = {1'b0, r_acc} + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, IN_sum};
    assign w_count_inc = r_count + CW'(1);

    always_ff @(posedge IN_clk or negedge IN_rst_n) begin
        if (!IN_rst_n) begin
            r_state <= ACCUM;
            r_ready <= 1'b0;
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_ready <= w_ready_n;
            r_acc   <= w_acc_n;
            r_count <= w_count_n;
            r_ovf   <= w_ovf_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_acc_n   = r_acc;
        w_count_n = r_count;
        w_ovf_n   = r_ovf;
        w_ready_n = 1'b0;
        case (r_state)
            ACCUM: begin
                if (w_accept) begin
                    w_acc_n   = w_sum_ext[ACC_WIDTH-1:0];
                    w_count_n = w_count_inc;
                    w_ovf_n   = r_ovf | w_sum_ext[ACC_WIDTH];
                end
                // A same-cycle sample is folded in before a flush closes the frame.
                if ((w_accept && (w_count_inc == CW'(COUNT))) ||
                    (IN_flush && ((r_count != '0) || w_accept))) begin
                    w_state_n = HOLD;
                end else begin
                    w_ready_n = 1'b1;
                end
            end
            HOLD: begin
                if (w_return) begin
                    w_state_n = ACCUM;
                    w_acc_n   = '0;
                    w_count_n = '0;
                    w_ovf_n   = 1'b0;
                    w_ready_n = 1'b1;
                end
            end
            default: begin
                w_state_n = ACCUM;
            end
        endcase
    end

    assign OUT_ready = r_ready;
    assign OUT_valid = (r_state == HOLD);
    assign OUT_acc   = r_acc;
    assign OUT_count = r_count;
    assign OUT_ovf   = r_ovf;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: a default-sized instance plus an
// 8-bit accumulator instance used for the wrap-around frames.
module tb_sum_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        valid = 1'b0, flush = 1'b0, in_ready = 1'b1;
    logic [7:0]  sum = '0;
    logic        out_ready, out_valid, out_ovf;
    logic [15:0] out_acc;
    logic [2:0]  out_count;

    logic        v8 = 1'b0, flush8 = 1'b0, in_ready8 = 1'b1;
    logic [7:0]  sum8 = '0;
    logic        out_ready8, out_valid8, out_ovf8;
    logic [7:0]  out_acc8;
    logic [2:0]  out_count8;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sum_accumulator u_dut (
        .IN_clk(clk), .IN_rst_n(rst_n),
        .IN_valid(valid), .OUT_ready(out_ready), .IN_sum(sum), .IN_flush(flush),
        .OUT_valid(out_valid), .IN_ready(in_ready),
        .OUT_acc(out_acc), .OUT_count(out_count), .OUT_ovf(out_ovf)
    );

    sum_accumulator #(.WIDTH(8), .ACC_WIDTH(8), .COUNT(4)) u_dut8 (
        .IN_clk(clk), .IN_rst_n(rst_n),
        .IN_valid(v8), .OUT_ready(out_ready8), .IN_sum(sum8), .IN_flush(flush8),
        .OUT_valid(out_valid8), .IN_ready(in_ready8),
        .OUT_acc(out_acc8), .OUT_count(out_count8), .OUT_ovf(out_ovf8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic rdy, input logic vld,
                             input logic [15:0] acc, input logic [2:0] cnt, input logic ovf);
        check({tag, ".ready"}, 32'(out_ready), 32'(rdy));
        check({tag, ".valid"}, 32'(out_valid), 32'(vld));
        check({tag, ".acc"},   32'(out_acc),   32'(acc));
        check({tag, ".count"}, 32'(out_count), 32'(cnt));
        check({tag, ".ovf"},   32'(out_ovf),   32'(ovf));
    endtask

    initial begin
        // Reset held for 3 cycles; outputs must be zero throughout.
        repeat (3) tick();
        check_all("reset", 1'b0, 1'b0, 16'd0, 3'd0, 1'b0);
        check("reset.ready8", 32'(out_ready8), 32'd0);
        rst_n = 1'b1;
        tick();
        check_all("idle", 1'b1, 1'b0, 16'd0, 3'd0, 1'b0);
        tick();
        check("idle.valid2", 32'(out_valid), 32'd0);

        // Full frame 10+20+30+40.
        valid = 1'b1;
        sum = 8'd10; tick();
        sum = 8'd20; tick();
        sum = 8'd30; tick();
        sum = 8'd40; tick();
        valid = 1'b0;
        check_all("full", 1'b0, 1'b1, 16'd100, 3'd4, 1'b0);
        tick();
        check("full.ready_after", 32'(out_ready), 32'd1);
        check("full.valid_after", 32'(out_valid), 32'd0);

        // Flush closes a partial frame of 5+7.
        valid = 1'b1;
        sum = 8'd5; tick();
        sum = 8'd7; tick();
        valid = 1'b0; flush = 1'b1; tick();
        flush = 1'b0;
        check_all("flush", 1'b0, 1'b1, 16'd12, 3'd2, 1'b0);
        tick();
        check("flush.ret_ready", 32'(out_ready), 32'd1);

        // Flush on an empty frame is ignored.
        flush = 1'b1; tick();
        flush = 1'b0;
        check_all("flush_empty", 1'b1, 1'b0, 16'd0, 3'd0, 1'b0);

        // Flush in the same cycle as accepting 3, after 5.
        valid = 1'b1;
        sum = 8'd5; tick();
        sum = 8'd3; flush = 1'b1; tick();
        valid = 1'b0; flush = 1'b0;
        check_all("flush_same", 1'b0, 1'b1, 16'd8, 3'd2, 1'b0);
        tick();

        // Backpressure: frame of 1s completes with IN_ready low, 9 waits upstream.
        in_ready = 1'b0;
        valid = 1'b1;
        sum = 8'd1;
        repeat (4) tick();
        sum = 8'd9;
        for (int i = 0; i < 5; i++) begin
            check_all($sformatf("bp%0d", i), 1'b0, 1'b1, 16'd4, 3'd4, 1'b0);
            tick();
        end
        in_ready = 1'b1;
        tick();
        check_all("bp_ret", 1'b1, 1'b0, 16'd0, 3'd0, 1'b0);
        tick();
        valid = 1'b0;
        check_all("bp_fresh", 1'b1, 1'b0, 16'd9, 3'd1, 1'b0);
        flush = 1'b1; tick();
        flush = 1'b0;
        check_all("bp_frame", 1'b0, 1'b1, 16'd9, 3'd1, 1'b0);
        tick();

        // Asynchronous reset mid-frame.
        valid = 1'b1;
        sum = 8'd50; tick();
        sum = 8'd60; tick();
        valid = 1'b0;
        check("mid.acc_before", 32'(out_acc), 32'd110);
        #3 rst_n = 1'b0;
        #1;
        check_all("mid_rst", 1'b0, 1'b0, 16'd0, 3'd0, 1'b0);
        #1 rst_n = 1'b1;
        tick();
        check("mid.ready", 32'(out_ready), 32'd1);
        valid = 1'b1;
        sum = 8'd1; tick();
        sum = 8'd2; tick();
        sum = 8'd3; tick();
        sum = 8'd4; tick();
        valid = 1'b0;
        check_all("mid_frame", 1'b0, 1'b1, 16'd10, 3'd4, 1'b0);
        tick();

        // 8-bit accumulator wrap: 200+100 = 300 -> 44 with overflow.
        v8 = 1'b1;
        sum8 = 8'd200; tick();
        sum8 = 8'd100; tick();
        sum8 = 8'd0;   tick();
        tick();
        v8 = 1'b0;
        check("wrap.valid", 32'(out_valid8), 32'd1);
        check("wrap.acc",   32'(out_acc8),   32'd44);
        check("wrap.ovf",   32'(out_ovf8),   32'd1);
        check("wrap.count", 32'(out_count8), 32'd4);
        tick();
        v8 = 1'b1;
        sum8 = 8'd1;
        repeat (4) tick();
        v8 = 1'b0;
        check("wrap2.valid", 32'(out_valid8), 32'd1);
        check("wrap2.acc",   32'(out_acc8),   32'd4);
        check("wrap2.ovf",   32'(out_ovf8),   32'd0);
        tick();
        check("wrap2.ready", 32'(out_ready8), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
